// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: turns one CPU fetch request at a time into a
// single memory read, with flush/kill handling and a stall-able result.
module ifetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_addr_err,
  input  logic              cpu_flush,
  input  logic              cpu_stall_req,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic              kill_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] data_q;

  // The result is only presented while the fetch stage still points at the
  // PC it was fetched for; a same-cycle flush hides it.
  assign cpu_rvalid = (state_q == S_DONE) && (cpu_pc == pc_q) && !cpu_flush;
  assign cpu_rdata  = cpu_rvalid ? data_q : '0;
  assign cpu_stall  = cpu_read && !cpu_flush && !cpu_addr_err && !cpu_rvalid;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_req_q ? addr_q : '0;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      pc_q      <= '0;
      // NOTE: the data register is reset too, so nothing stale can ever
      // reach cpu_rdata after a reset.
      data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_read && !cpu_addr_err && !cpu_flush) begin
            addr_q    <= cpu_addr;
            pc_q      <= cpu_pc;
            kill_q    <= 1'b0;
            mem_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (cpu_flush) kill_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cpu_flush) kill_q <= 1'b1;
          if (mem_rvalid) begin
            // A flush arriving with the data kills it just like an earlier one.
            if (!kill_q && !cpu_flush) begin
              data_q  <= mem_rdata;
              state_q <= S_DONE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (cpu_flush || (cpu_pc != pc_q) || !cpu_stall_req) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
